iir_biquad_sequencer: RTL
=========================

Name: iir_biquad_sequencer

Overview:
- Time-multiplexed fixed-point biquad (direct form I) controller. Sequences one shared multiply-accumulate unit across the five taps b0, b1, b2, a1, a2 for each audio sample.
- Owns the x/y delay lines and a double-buffered coefficient bank. New coefficients take effect only on sample boundaries.
- Sits between the audio sample source and the codec output path. It is a low-resource alternative to the five-multiplier floating-point iir.

Parameters:
- AW, 24, audio sample width, signed two's complement.
- CW, 18, coefficient width, signed Q2.16 (65536 = 1.0).
- FRAC, 16, coefficient fractional bits; the accumulator is shifted right by FRAC.

Ports:
- clk  in  1  system clock
- rst_b  in  1  asynchronous active-low reset
- in_valid  in  1  audio_in holds a sample
- in_ready  out  1  block can accept a sample
- audio_in  in  AW  input sample
- out_valid  out  1  one-cycle pulse; audio_out is new
- audio_out  out  AW  filtered sample, held until the next out_valid
- out_sat  out  1  high with out_valid when the result was clamped
- busy  out  1  high in any state other than IDLE
- coef_wr  in  1  write coef_data into the shadow bank
- coef_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; addresses 5-7 are ignored
- coef_data  in  CW  coefficient value; a1 and a2 are supplied pre-negated
- coef_commit  in  1  request a shadow-to-active copy
- flush  in  1  request zeroing of the delay lines

Behaviour:
- Clock and reset: single clock domain. rst_b is asynchronous and active-low.
- Reset values: state=IDLE; in_ready=1; busy=0; out_valid=0; out_sat=0; audio_out=0; x1, x2, y1, y2=0; shadow and active coefficients=0; pending_commit=0; pending_flush=0.
- States and transitions:
  - IDLE → MAC on in_valid&in_ready. The accept edge (T0) captures audio_in as x0 and clears the accumulator.
  - MAC: tap index 0..4, one tap per edge T1..T5. acc <= acc + coef[k]*operand[k], with operands x0, x1, x2, y1, y2 in tap order.
  - MAC → OUT after tap 4.
  - OUT → IDLE on edge T6, which also performs the output and delay-line updates below.
- Output update on T6:
  - audio_out <= sat(round(acc)).
  - out_valid=1 and out_sat are valid for the cycle after T6. Latency from accept to out_valid is 6 clocks.
  - Delay lines: x2<=x1, x1<=x0, y2<=y1, y1<=the saturated output (not the raw accumulator).
- Throughput: in_ready = (state==IDLE), so the earliest next accept is T7 (one sample per 7 clocks max). in_valid while busy is ignored, with no queuing.
- Arithmetic widths: products are CW+AW = 42 bits signed; the accumulator is 45 bits signed and cannot overflow over 5 taps.
- Rounding and saturation:
  - round = (acc + 2^(FRAC-1)) >>> FRAC, arithmetic shift, so halves round toward +inf.
  - sat clamps to [-2^(AW-1), 2^(AW-1)-1]. out_sat=1 iff the clamp changed the value.
- Coefficient writes:
  - coef_wr writes the shadow bank on the same edge, at any state.
  - coef_commit sets pending_commit. While pending_commit is set and state==IDLE, active<=shadow and pending_commit clears on that edge.
  - The earliest copy is therefore the edge after commit, so a wr+commit in the same cycle includes that write.
  - If the copy edge is also an accept edge, the sample uses the new coefficients.
  - A commit arriving during MAC/OUT is deferred, and the in-flight sample uses the old bank.
- Flush:
  - flush sets pending_flush; the delay-line zeroing is applied on an IDLE edge, under the same rules as commit.
  - If flush and accept coincide on one edge, the delay lines are zeroed before that sample uses them: the sample sees x1=x2=y1=y2=0.
  - Flush does not affect audio_out.
- Reset mid-operation: an async reset aborts immediately. There is no out_valid for the aborted sample, and all state returns to the reset values.

Test Plan:
- Passthrough: commit b0=65536, others 0; send 1000 → out_valid exactly 6 clocks after accept with audio_out=1000, out_sat=0; in_ready low for 6 cycles.
- Delay tap: b1=32768 only; send 4000 then 0 → outputs 0, then 2000. Rounding check with b0=32768: inputs 3, -3 → outputs 2, -1.
- Feedback: b0=65536, a1=32768; send 8000, 0, 0 → outputs 8000, 4000, 2000. Then flush and send 0 → output 0.
- Saturation: b0=131071; send 8388607 → output 8388607 with out_sat=1. Send -8388608 → output -8388608 with out_sat=1.
- Deferred commit: b0=65536 active; during tap 2 of a sample of 100, write b0=32768 and commit → that sample outputs 100; next sample of 100 outputs 50. Also cover in_valid held while busy → no extra accept.
- Reset mid-MAC: assert rst_b low at tap 2 → no out_valid; in_ready=1; coefficients 0. After release, a sample of 500 → output 0.

Source files
------------

// File: rtl/iir_biquad_sequencer.sv
// ---------------------------------------------------------------------------
// iir_biquad_sequencer
//
// Direct-form-I biquad that time-multiplexes one multiply-accumulate unit
// over the five taps (b0, b1, b2, a1, a2) of each audio sample. It owns the
// x/y delay lines and a double-buffered coefficient bank. Coefficient updates
// and delay-line flushes are only applied while the sequencer is idle, so a
// sample in flight always sees one consistent bank.
//
// Ports:
//   clk, rst_b              clock, asynchronous active-low reset
//   in_valid/in_ready       sample handshake; in_ready is high only in IDLE
//   audio_in                signed input sample (AW bits)
//   out_valid               one-cycle pulse when audio_out is updated
//   audio_out               signed filtered sample, held between pulses
//   out_sat                 high with out_valid when the result was clamped
//   busy                    high whenever a sample is being processed
//   coef_wr/addr/data       shadow coefficient write (a1/a2 pre-negated)
//   coef_commit             request shadow-to-active copy at the next idle edge
//   flush                   request delay-line zeroing at the next idle edge
// ---------------------------------------------------------------------------
module iir_biquad_sequencer #(
    parameter int AW   = 24,
    parameter int CW   = 18,
    parameter int FRAC = 16
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] audio_in,
    output logic          out_valid,
    output logic [AW-1:0] audio_out,
    output logic          out_sat,
    output logic          busy,
    input  logic          coef_wr,
    input  logic [2:0]    coef_addr,
    input  logic [CW-1:0] coef_data,
    input  logic          coef_commit,
    input  logic          flush
);

    localparam int PW   = CW + AW;
    localparam int ACCW = PW + 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic signed [ACCW-1:0] ROUND_HALF = ACCW'(2 ** (FRAC - 1));
    localparam logic signed [ACCW-1:0] SAT_MAX    = ACCW'(2 ** (AW - 1) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN    = ~SAT_MAX;
    localparam logic [AW-1:0]          OUT_HI     = {1'b0, {(AW - 1){1'b1}}};
    localparam logic [AW-1:0]          OUT_LO     = {1'b1, {(AW - 1){1'b0}}};

    logic [1:0]             state;
    logic [2:0]             tap;
    logic signed [AW-1:0]   x0, x1, x2, y1, y2;
    logic signed [CW-1:0]   shadow_coef [5];
    logic signed [CW-1:0]   active_coef [5];
    logic signed [ACCW-1:0] acc;
    logic                   pending_commit;
    logic                   pending_flush;

    logic signed [CW-1:0]   coef_sel;
    logic signed [AW-1:0]   operand_sel;
    logic signed [PW-1:0]   product;
    logic signed [ACCW-1:0] acc_rounded;
    logic signed [ACCW-1:0] acc_shifted;
    logic [AW-1:0]          sat_value;
    logic                   sat_hit;

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    // Tap selection pairs each coefficient with its operand; the rounding
    // and clamp path is evaluated continuously but only captured in OUT.
    always_comb begin
        coef_sel    = '0;
        operand_sel = '0;
        case (tap)
            3'd0: begin coef_sel = active_coef[0]; operand_sel = x0; end
            3'd1: begin coef_sel = active_coef[1]; operand_sel = x1; end
            3'd2: begin coef_sel = active_coef[2]; operand_sel = x2; end
            3'd3: begin coef_sel = active_coef[3]; operand_sel = y1; end
            3'd4: begin coef_sel = active_coef[4]; operand_sel = y2; end
            default: begin coef_sel = '0; operand_sel = '0; end
        endcase
        product     = PW'(coef_sel) * PW'(operand_sel);
        acc_rounded = acc + ROUND_HALF;
        acc_shifted = acc_rounded >>> FRAC;
        sat_hit     = 1'b0;
        sat_value   = acc_shifted[AW-1:0];
        if (acc_shifted > SAT_MAX) begin
            sat_value = OUT_HI;
            sat_hit   = 1'b1;
        end else if (acc_shifted < SAT_MIN) begin
            sat_value = OUT_LO;
            sat_hit   = 1'b1;
        end
    end

    // Sequencer, accumulator, output register and delay lines. A pending
    // flush is applied before an accept on the same edge, so that sample
    // already sees cleared history.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state         <= ST_IDLE;
            tap           <= '0;
            acc           <= '0;
            x0            <= '0;
            x1            <= '0;
            x2            <= '0;
            y1            <= '0;
            y2            <= '0;
            audio_out     <= '0;
            out_valid     <= 1'b0;
            out_sat       <= 1'b0;
            pending_flush <= 1'b0;
        end else begin
            out_valid     <= 1'b0;
            out_sat       <= 1'b0;
            pending_flush <= flush | (pending_flush & (state != ST_IDLE));
            case (state)
                ST_IDLE: begin
                    if (pending_flush) begin
                        x1 <= '0;
                        x2 <= '0;
                        y1 <= '0;
                        y2 <= '0;
                    end
                    if (in_valid) begin
                        x0    <= audio_in;
                        acc   <= '0;
                        tap   <= '0;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= acc + ACCW'(product);
                    if (tap == 3'd4) begin
                        state <= ST_OUT;
                    end else begin
                        tap <= tap + 3'd1;
                    end
                end
                ST_OUT: begin
                    audio_out <= sat_value;
                    out_sat   <= sat_hit;
                    out_valid <= 1'b1;
                    x2        <= x1;
                    x1        <= x0;
                    y2        <= y1;
                    y1        <= sat_value;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Shadow writes land immediately; the active bank only changes on an
    // idle edge so an in-flight sample never mixes old and new taps.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < 5; i++) begin
                shadow_coef[i] <= '0;
                active_coef[i] <= '0;
            end
            pending_commit <= 1'b0;
        end else begin
            if (coef_wr && (coef_addr <= 3'd4)) begin
                shadow_coef[coef_addr] <= coef_data;
            end
            if (pending_commit && (state == ST_IDLE)) begin
                for (int i = 0; i < 5; i++) begin
                    active_coef[i] <= shadow_coef[i];
                end
            end
            pending_commit <= coef_commit | (pending_commit & (state != ST_IDLE));
        end
    end

endmodule
